// File: rtl/cell_fetch_unit.sv
// cell_fetch_unit
//
// Heap-cell fetch engine for the Lisp core. A request carries a cell base
// address; the unit reads the tag word from a fixed-latency pipelined memory,
// decodes how many payload words the tag implies, reads those words
// back-to-back and returns the decoded cell on a valid/ready response port.
// Unknown tags, cells running off the end of memory and memory faults are
// reported through resp_error / resp_err_code.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready/req_addr request handshake and cell base address
//   resp_valid/resp_ready        response handshake
//   resp_tag, resp_word0/1       tag word and payload words (0 when unused)
//   resp_error, resp_err_code    error flag; 0 none, 1 tag, 2 bounds, 3 mem
//   mem_rd_en, mem_addr          registered one-cycle read strobe and address
//   mem_rd_data, mem_error       read data (MEM_LATENCY after strobe), fault
//   busy                         high whenever the unit is not idle
module cell_fetch_unit #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned MEM_WORDS   = 2**ADDR_WIDTH,
  parameter int unsigned TAG_NIL     = 0,
  parameter int unsigned TAG_NUMBER  = 1,
  parameter int unsigned TAG_SYMBOL  = 3,
  parameter int unsigned TAG_CONS    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_tag,
  output logic [DATA_WIDTH-1:0] resp_word0,
  output logic [DATA_WIDTH-1:0] resp_word1,
  output logic                  resp_error,
  output logic [1:0]            resp_err_code,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_error,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_TAG_ISSUE, S_TAG_WAIT, S_PAY_ISSUE, S_PAY_WAIT, S_RESP
  } state_e;

  // Which word a read strobe fetched; travels with the read to its return.
  typedef enum logic [1:0] { K_TAG, K_W0, K_W1 } kind_e;

  typedef struct packed {
    logic  valid;
    kind_e kind;
  } token_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_TAG    = 2'd1;
  localparam logic [1:0] ERR_BOUNDS = 2'd2;
  localparam logic [1:0] ERR_MEM    = 2'd3;

  // Highest legal address, one bit wider than an address so base+n cannot wrap.
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(MEM_WORDS - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [1:0]            n_q, n_d;
  logic [DATA_WIDTH-1:0] tag_q, tag_d;
  logic [DATA_WIDTH-1:0] w0_q, w0_d;
  logic [DATA_WIDTH-1:0] w1_q, w1_d;
  logic [1:0]            code_q, code_d;
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  kind_e                 rd_kind_q, rd_kind_d;
  token_t                tok_q [MEM_LATENCY];
  token_t                tok_out;
  logic                  flush;

  logic                  tag_known;
  logic [1:0]            dec_n;
  logic [ADDR_WIDTH:0]   pay_end;
  logic                  bounds_fail;
  logic                  in_fetch;

  assign tok_out     = tok_q[MEM_LATENCY-1];
  assign in_fetch    = state_q inside {S_TAG_ISSUE, S_TAG_WAIT, S_PAY_ISSUE, S_PAY_WAIT};
  assign pay_end     = {1'b0, base_q} + (ADDR_WIDTH+1)'(dec_n);
  assign bounds_fail = pay_end > LAST_ADDR;

  // Tag decode of the word currently on the read-data bus.
  // NOTE: every variable gets a default before any branch, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    tag_known = 1'b1;
    dec_n     = 2'd0;
    if (mem_rd_data == DATA_WIDTH'(TAG_NIL)) begin
      dec_n = 2'd0;
    end else if (mem_rd_data == DATA_WIDTH'(TAG_NUMBER) ||
                 mem_rd_data == DATA_WIDTH'(TAG_SYMBOL)) begin
      dec_n = 2'd1;
    end else if (mem_rd_data == DATA_WIDTH'(TAG_CONS)) begin
      dec_n = 2'd2;
    end else begin
      tag_known = 1'b0;
    end
  end

  // State register and datapath registers.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      n_q         <= '0;
      tag_q       <= '0;
      w0_q        <= '0;
      w1_q        <= '0;
      code_q      <= ERR_NONE;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      rd_kind_q   <= K_TAG;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      n_q         <= n_d;
      tag_q       <= tag_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      code_q      <= code_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      rd_kind_q   <= rd_kind_d;
    end
  end

  // Token pipeline: one stage per cycle of memory latency, so a token leaves
  // the last stage in the same cycle its read data is on mem_rd_data.
  // NOTE: this small array is reset (and flushed on a fault) on purpose; a
  // stale valid bit would capture a return from an abandoned read.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < int'(MEM_LATENCY); i++) tok_q[i] <= '0;
    end else begin
      tok_q[0] <= '{valid: mem_rd_en_q, kind: rd_kind_q};
      for (int i = 1; i < int'(MEM_LATENCY); i++) tok_q[i] <= tok_q[i-1];
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    n_d         = n_q;
    tag_d       = tag_q;
    w0_d        = w0_q;
    w1_d        = w1_q;
    code_d      = code_q;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    rd_kind_d   = rd_kind_q;
    flush       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          base_d      = req_addr;
          n_d         = 2'd0;
          tag_d       = '0;
          w0_d        = '0;
          w1_d        = '0;
          code_d      = ERR_NONE;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = req_addr;
          rd_kind_d   = K_TAG;
          state_d     = S_TAG_ISSUE;
        end
      end
      S_TAG_ISSUE: state_d = S_TAG_WAIT;
      S_TAG_WAIT: begin
        if (tok_out.valid && tok_out.kind == K_TAG) begin
          tag_d = mem_rd_data;
          if (!tag_known) begin
            code_d  = ERR_TAG;
            state_d = S_RESP;
          end else if (bounds_fail) begin
            code_d  = ERR_BOUNDS;
            state_d = S_RESP;
          end else if (dec_n == 2'd0) begin
            state_d = S_RESP;
          end else begin
            n_d         = dec_n;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = base_q + ADDR_WIDTH'(1);
            rd_kind_d   = K_W0;
            state_d     = S_PAY_ISSUE;
          end
        end
      end
      S_PAY_ISSUE: begin
        // The strobe on the bus this cycle is for rd_kind_q; follow a car read
        // with the cdr read when the cell has two payload words.
        if (rd_kind_q == K_W0 && n_q == 2'd2) begin
          mem_rd_en_d = 1'b1;
          mem_addr_d  = base_q + ADDR_WIDTH'(2);
          rd_kind_d   = K_W1;
        end else begin
          state_d = S_PAY_WAIT;
        end
      end
      S_PAY_WAIT: ;
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Payload returns can land while the cdr is still being issued (latency 1).
    if ((state_q == S_PAY_ISSUE || state_q == S_PAY_WAIT) && tok_out.valid) begin
      if (tok_out.kind == K_W0) w0_d = mem_rd_data;
      if (tok_out.kind == K_W1) w1_d = mem_rd_data;
      if (tok_out.kind == K_W1 || (tok_out.kind == K_W0 && n_q == 2'd1)) begin
        state_d = S_RESP;
      end
    end

    // A memory fault overrides everything else in the same cycle, including a
    // data return: stop issuing, drop in-flight reads and report.
    if (in_fetch && mem_error) begin
      tag_d       = '0;
      w0_d        = '0;
      w1_d        = '0;
      code_d      = ERR_MEM;
      mem_rd_en_d = 1'b0;
      mem_addr_d  = mem_addr_q;
      flush       = 1'b1;
      state_d     = S_RESP;
    end
  end

  // Outputs.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    resp_valid = (state_q == S_RESP);
  end

  assign resp_tag      = tag_q;
  assign resp_word0    = w0_q;
  assign resp_word1    = w1_q;
  assign resp_err_code = code_q;
  assign resp_error    = (code_q != ERR_NONE);
  assign mem_rd_en     = mem_rd_en_q;
  assign mem_addr      = mem_addr_q;

endmodule
